pmbist_sequencer: RTL and testbench

PMBIST_SEQUENCER -- requirements
Module: pmbist_sequencer

---
 rtl/pmbist_sequencer_pkg.sv | 22 ++
 rtl/pmbist_addr_counter.sv | 47 ++++
 rtl/pmbist_sequencer.sv | 120 ++++++++++++
 tb/tb_pmbist_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmbist_sequencer_pkg.sv
// Shared PMBIST definitions: sequencer state encoding, element direction
// constants and instruction-register field widths.
package pmbist_sequencer_pkg;

  // Instruction register field widths
  localparam int unsigned IR_UPDWN_W = 1;
  localparam int unsigned IR_NOPS_W  = 3;
  localparam int unsigned IR_TE_W    = 1;

  // Element direction
  localparam logic UPDWN_ASC  = 1'b0;
  localparam logic UPDWN_DESC = 1'b1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLoad  = 3'd2,
    StExec  = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/pmbist_addr_counter.sv
// Address stepper for one march element.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - start a new element: latch direction/limit, set the start address
//   updwn     - direction of the element being loaded (UPDWN_ASC / UPDWN_DESC)
//   addr_max  - last address of the memory under test (sampled on load)
//   step      - advance one address in the latched direction
//   addr      - current test address
//   at_end    - current address is the element's last one
module pmbist_addr_counter
  import pmbist_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              updwn,
  input  logic [ADDR_W-1:0] addr_max,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              at_end
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] lim_q;
  logic              dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      lim_q  <= '0;
      dir_q  <= UPDWN_ASC;
    end else if (load) begin
      lim_q  <= addr_max;
      dir_q  <= updwn;
      addr_q <= (updwn == UPDWN_DESC) ? addr_max : '0;
    end else if (step && !at_end) begin
      // Never step past the end address; the element ends there instead.
      addr_q <= (dir_q == UPDWN_DESC) ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
    end
  end

  assign at_end = (dir_q == UPDWN_DESC) ? (addr_q == '0) : (addr_q == lim_q);
  assign addr   = addr_q;

endmodule

// File: rtl/pmbist_sequencer.sv
// Programmable memory BIST sequencer. Fetches march elements from a program
// store (1-cycle registered read) and walks each element over the address
// range, issuing (nops+1) ops per address.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - test start pulse (honoured in idle only)
//   addr_max            - last address of the memory under test
//   pc                  - program-store read address
//   instr_updwn/nops/te - fetched element fields
//   ir_hold             - low for the single cycle the instruction is loaded
//   stall               - pauses op issue while high
//   mem_addr, op_idx    - current test address and op within the element
//   op_valid            - op accepted this cycle
//   busy, done          - test in progress, one-cycle completion pulse
module pmbist_sequencer
  import pmbist_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned PC_W   = 4,
  parameter int unsigned OPW    = IR_NOPS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_max,
  output logic [PC_W-1:0]   pc,
  input  logic              instr_updwn,
  input  logic [OPW-1:0]    instr_nops,
  input  logic              instr_te,
  output logic              ir_hold,
  input  logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OPW-1:0]    op_idx,
  output logic              op_valid,
  output logic              busy,
  output logic              done
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [OPW-1:0]  op_idx_q;
  logic [OPW-1:0]  nops_q;

  logic accept;
  logic last_op;
  logic ld_addr;
  logic step_addr;
  logic at_end;

  assign accept    = (state_q == StExec) && !stall;
  assign last_op   = (op_idx_q == nops_q);
  // A terminate instruction leaves the address untouched.
  assign ld_addr   = (state_q == StLoad) && !instr_te;
  assign step_addr = accept && last_op;

  pmbist_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_addr),
    .updwn    (instr_updwn),
    .addr_max (addr_max),
    .step     (step_addr),
    .addr     (mem_addr),
    .at_end   (at_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      op_idx_q <= '0;
      nops_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: state_q <= StLoad;
        StLoad: begin
          nops_q   <= instr_nops;
          op_idx_q <= '0;
          state_q  <= instr_te ? StDone : StExec;
        end
        StExec: begin
          if (accept) begin
            if (!last_op) begin
              op_idx_q <= op_idx_q + OPW'(1);
            end else begin
              op_idx_q <= '0;
              if (at_end) begin
                // The last program slot ends the test rather than wrapping pc.
                if (&pc_q) begin
                  state_q <= StDone;
                end else begin
                  pc_q    <= pc_q + PC_W'(1);
                  state_q <= StFetch;
                end
              end
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pc       = pc_q;
  assign op_idx   = op_idx_q;
  assign op_valid = accept;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign ir_hold  = (state_q != StLoad);

endmodule

// File: tb/tb_pmbist_sequencer.sv
// Bench for pmbist_sequencer: table-driven programs, randomized programs with
// random stall/start/junk inputs, and hand sequences for reset and pc limit.
module tb_pmbist_sequencer;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned PC_W   = 4;
  localparam int unsigned OPW    = 3;
  localparam logic [4:0]  TE_EL  = 5'b10000;  // {te, updwn, nops[2:0]}

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] addr_max;
  logic [PC_W-1:0]   pc;
  logic              instr_updwn;
  logic [OPW-1:0]    instr_nops;
  logic              instr_te;
  logic              ir_hold;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [OPW-1:0]    op_idx;
  logic              op_valid;
  logic              busy;
  logic              done;

  pmbist_sequencer #(
    .ADDR_W (ADDR_W),
    .PC_W   (PC_W),
    .OPW    (OPW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .addr_max    (addr_max),
    .pc          (pc),
    .instr_updwn (instr_updwn),
    .instr_nops  (instr_nops),
    .instr_te    (instr_te),
    .ir_hold     (ir_hold),
    .stall       (stall),
    .mem_addr    (mem_addr),
    .op_idx      (op_idx),
    .op_valid    (op_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] prog [16];

  // Reference results
  int exp_addr[$];
  int exp_op[$];
  int exp_loads;
  int exp_pc;
  bit exp_te_end;

  typedef struct packed {
    logic [7:0]      am;
    logic [3:0][4:0] el;
    logic [15:0]     n_ops;
    logic [7:0]      n_loads;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] mk_el(input bit te, input bit dn, input int nops);
    return {te, dn, 3'(nops)};
  endfunction

  function automatic vec_t mk_vec(input int am, input logic [4:0] e0, input logic [4:0] e1,
                                  input logic [4:0] e2, input logic [4:0] e3,
                                  input int ops, input int loads);
    vec_t v;
    v.am      = 8'(am);
    v.el[0]   = e0;
    v.el[1]   = e1;
    v.el[2]   = e2;
    v.el[3]   = e3;
    v.n_ops   = 16'(ops);
    v.n_loads = 8'(loads);
    return v;
  endfunction

  // Walk the program as the test engineer reads it: elements in order, each
  // element visits every address in its direction, nops+1 ops per address.
  task automatic model(input int am);
    exp_addr.delete();
    exp_op.delete();
    exp_loads  = 0;
    exp_te_end = 1'b0;
    for (int p = 0; p < 16; p++) begin
      exp_loads++;
      exp_pc = p;
      if (prog[p][4]) begin
        exp_te_end = 1'b1;
        return;
      end
      for (int k = 0; k <= am; k++) begin
        for (int o = 0; o <= int'(prog[p][2:0]); o++) begin
          exp_addr.push_back(prog[p][3] ? am - k : k);
          exp_op.push_back(o);
        end
      end
    end
  endtask

  task automatic drive_instr();
    instr_te    = prog[pc][4];
    instr_updwn = prog[pc][3];
    instr_nops  = prog[pc][2:0];
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pc"}, 64'(pc), 0);
    chk({tag, " mem_addr"}, 64'(mem_addr), 0);
    chk({tag, " op_idx"}, 64'(op_idx), 0);
    chk({tag, " op_valid"}, 64'(op_valid), 0);
    chk({tag, " busy"}, 64'(busy), 0);
    chk({tag, " done"}, 64'(done), 0);
    chk({tag, " ir_hold"}, 64'(ir_hold), 1);
  endtask

  // Run one test from idle; stall and junk inputs are randomized, start is
  // re-pulsed while busy when noisy is set.
  task automatic run(input string name, input int am, input int stall_pct, input bit noisy,
                     output int n_ops, output int n_load);
    int first_load, last_load, first_op, last_op, done_cyc, n_done, bad, sviol, pc_done;
    bit idle_after;
    model(am);
    n_ops = 0; n_load = 0; first_load = -1; last_load = -1; first_op = -1; last_op = -1;
    done_cyc = -1; n_done = 0; bad = 0; sviol = 0; pc_done = -1; idle_after = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      start = (cyc == 0) || (noisy && busy && ($urandom_range(0, 2) == 0));
      stall = (cyc >= 4) && (int'($urandom_range(0, 99)) < stall_pct);
      if (!ir_hold) begin
        addr_max = 8'(am);
        drive_instr();
      end else if (noisy) begin
        addr_max    = 8'($urandom);
        instr_te    = 1'($urandom);
        instr_updwn = 1'($urandom);
        instr_nops  = 3'($urandom);
      end
      #1;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        idle_after = !busy && !done;
        break;
      end
      if (!ir_hold) begin
        n_load++;
        if (first_load < 0) first_load = cyc;
        last_load = cyc;
      end
      if (op_valid) begin
        if (n_ops >= exp_addr.size() || int'(mem_addr) != exp_addr[n_ops]
            || int'(op_idx) != exp_op[n_ops]) bad++;
        if (first_op < 0) first_op = cyc;
        last_op = cyc;
        n_ops++;
      end
      if (stall && op_valid) sviol++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        pc_done  = int'(pc);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    stall = 1'b0;
    chk({name, " done_count"}, 64'(n_done), 1);
    chk({name, " op_count"}, 64'(n_ops), 64'(exp_addr.size()));
    chk({name, " op_stream_errors"}, 64'(bad), 0);
    chk({name, " ir_loads"}, 64'(n_load), 64'(exp_loads));
    chk({name, " first_load_cycle"}, 64'(first_load), 2);
    if (!prog[0][4]) chk({name, " first_op_cycle"}, 64'(first_op), 3);
    chk({name, " done_cycle"}, 64'(done_cyc),
        64'(exp_te_end ? last_load + 1 : last_op + 1));
    chk({name, " pc_at_done"}, 64'(pc_done), 64'(exp_pc));
    chk({name, " op_valid_in_stall"}, 64'(sviol), 0);
    chk({name, " idle_after_done"}, 64'(idle_after), 1);
  endtask

  initial begin
    int n_ops, n_load, nel;
    bit hit;
    rst = 1'b1; start = 1'b0; stall = 1'b0; addr_max = '0;
    instr_updwn = 1'b0; instr_nops = '0; instr_te = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = TE_EL;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // Table-driven programs with hand-counted totals
    vecs[0] = mk_vec(3, mk_el(0, 0, 1), TE_EL, TE_EL, TE_EL, 8, 2);
    vecs[1] = mk_vec(2, mk_el(0, 1, 0), TE_EL, TE_EL, TE_EL, 3, 2);
    vecs[2] = mk_vec(0, mk_el(0, 0, 2), mk_el(0, 1, 0), TE_EL, TE_EL, 4, 3);
    vecs[3] = mk_vec(5, mk_el(0, 1, 3), mk_el(0, 0, 0), TE_EL, TE_EL, 30, 3);
    vecs[4] = mk_vec(4, TE_EL, TE_EL, TE_EL, TE_EL, 0, 1);
    vecs[5] = mk_vec(1, mk_el(0, 0, 7), TE_EL, TE_EL, TE_EL, 16, 2);
    vecs[6] = mk_vec(7, mk_el(0, 1, 1), mk_el(0, 0, 2), mk_el(0, 1, 0), mk_el(0, 0, 0), 56, 5);
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 16; i++) prog[i] = (i < 4) ? vecs[v].el[i] : TE_EL;
      run($sformatf("vec%0d", v), int'(vecs[v].am), (v == 3) ? 30 : 0, 1'b0, n_ops, n_load);
      chk($sformatf("vec%0d table_ops", v), 64'(n_ops), 64'(vecs[v].n_ops));
      chk($sformatf("vec%0d table_loads", v), 64'(n_load), 64'(vecs[v].n_loads));
    end

    // Sixteen non-terminating elements: pc must stop at 15
    for (int i = 0; i < 16; i++) prog[i] = mk_el(0, 0, 0);
    run("pc_limit", 0, 0, 1'b0, n_ops, n_load);
    chk("pc_limit ops", 64'(n_ops), 16);
    chk("pc_limit pc_held", 64'(pc), 15);
    for (int i = 0; i < 16; i++) prog[i] = mk_el(0, i % 2, $urandom_range(0, 1));
    run("pc_limit_mixed", 2, 20, 1'b1, n_ops, n_load);

    // Reset while executing at address 5
    for (int i = 0; i < 16; i++) prog[i] = TE_EL;
    prog[0] = mk_el(0, 0, 0);
    hit = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; addr_max = 8'd9; drive_instr();
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (!ir_hold) drive_instr();
      #1;
      if (op_valid && mem_addr == 8'd5) begin
        hit = 1'b1;
        break;
      end
    end
    chk("rst_exec reached_addr5", 64'(hit), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset("rst_exec");
    n_ops = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done || busy) n_ops++;
    end
    chk("rst_exec no_done_after", 64'(n_ops), 0);
    // Reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_over_start busy", 64'(busy), 0);
    prog[0] = mk_el(0, 1, 1);
    run("after_rst", 4, 10, 1'b0, n_ops, n_load);

    // Randomized programs with stalls, stray start pulses and junk inputs
    for (int r = 0; r < 12; r++) begin
      nel = $urandom_range(0, 4);
      for (int i = 0; i < 16; i++)
        prog[i] = (i < nel) ? mk_el(0, $urandom_range(0, 1), $urandom_range(0, 3)) : TE_EL;
      run($sformatf("rand%0d", r), $urandom_range(0, 7), $urandom_range(0, 40), 1'b1,
          n_ops, n_load);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
